// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, drives the instruction bus with a held request, and
// buffers returned instructions in a DEPTH-entry FIFO towards decode.
module fetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_addr_ok,
    input  logic            iresp_data_ok,
    input  logic [ILEN-1:0] iresp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_raw_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            out_is_bubble
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_addr;
    logic [ILEN-1:0] r_instr_mem [DEPTH];
    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic w_issue;
    logic w_busy;
    logic w_push;
    logic w_pop;
    logic w_unused;

    // A new request only starts from IDLE; an outstanding one already owns its slot.
    assign w_issue = (r_state == S_IDLE) && (r_count < CW'(DEPTH));
    assign w_busy  = w_issue || (r_state != S_IDLE);
    assign w_push  = w_busy && iresp_data_ok && (r_state != S_DISCARD) && !redirect_valid;
    assign w_pop   = (r_count != '0) && out_ready && !redirect_valid;

    assign ireq_valid = w_busy && !reset;
    assign ireq_addr  = (r_state == S_IDLE) ? r_pc : r_req_addr;

    assign out_valid     = (r_count != '0);
    assign out_is_bubble = ~out_valid;
    assign out_pc        = out_valid ? r_pc_mem[r_head]    : '0;
    assign out_raw_instr = out_valid ? r_instr_mem[r_head] : '0;

    // Address acceptance does not affect the hold rule; low redirect bits are forced to zero.
    assign w_unused = iresp_addr_ok ^ (^redirect_pc[1:0]);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = (w_busy && !iresp_data_ok) ? S_DISCARD : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_issue && !iresp_data_ok) w_state_nxt = S_WAIT;
                S_WAIT:    if (iresp_data_ok) w_state_nxt = S_IDLE;
                S_DISCARD: if (iresp_data_ok) w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= PC_RESET;
            r_req_addr <= PC_RESET;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) r_req_addr <= r_pc;
            if (redirect_valid) r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            else if (w_push)    r_pc <= r_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop)  r_head <= r_head + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; out_* are masked by out_valid so stale entries never leak.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_tail] <= iresp_data;
            r_pc_mem[r_tail]    <= ireq_addr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand-written corner
// sequences and a randomized run, all compared against a queue-based reference model.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] PC_RESET = 64'h8000_0000;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_raw_instr;
    logic [63:0] out_pc;
    logic        out_is_bubble;

    fetch_queue #(
        .DEPTH(DEPTH), .XLEN(64), .ILEN(32), .PC_RESET(PC_RESET)
    ) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_raw_instr(out_raw_instr),
        .out_pc(out_pc), .out_is_bubble(out_is_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } entry_t;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          exp_req;
        logic [63:0] exp_addr;
        bit          exp_ov;
        logic [63:0] exp_pc;
    } vec_t;

    // Reference model: queue contents, fetch PC and the one outstanding bus request.
    entry_t      q[$];
    logic [63:0] m_pc;
    bit          m_busy;
    bit          m_disc;
    logic [63:0] m_addr;
    bit          m_init;

    // Memory model: responds mem_lat cycles after a request first appears.
    int mem_wait;
    int mem_lat;
    int lat_mode;

    bit          d_rst, d_rdr, d_rdy, d_ok, e_req;
    logic [63:0] d_rpc, e_addr;

    int n_checks;
    int n_fail;

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic new_lat();
        mem_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
    endtask

    // Apply one cycle of inputs at the falling edge and compare DUT outputs with the model.
    task automatic drive(input bit rst, input bit rdr, input logic [63:0] rpc, input bit rdy);
        logic [63:0] exp_pc;
        logic [63:0] exp_instr;
        @(negedge clk);
        d_rst = rst; d_rdr = rdr; d_rpc = rpc; d_rdy = rdy;
        reset = rst; redirect_valid = rdr; redirect_pc = rpc; out_ready = rdy;
        e_req  = !rst && (m_busy || q.size() < DEPTH);
        e_addr = m_busy ? m_addr : m_pc;
        d_ok   = e_req && (mem_wait >= mem_lat);
        iresp_data_ok = d_ok;
        iresp_addr_ok = e_req && (mem_wait == 0);
        iresp_data    = d_ok ? mem_data(e_addr) : $urandom;
        #1;
        if (m_init || rst) check("ireq_valid", ireq_valid, e_req);
        if (m_init) begin
            if (e_req) check("ireq_addr", ireq_addr, e_addr);
            exp_pc = '0;
            exp_instr = '0;
            if (q.size() != 0) begin
                exp_pc = q[0].pc;
                exp_instr = q[0].instr;
            end
            check("out_valid", out_valid, q.size() != 0);
            check("out_is_bubble", out_is_bubble, q.size() == 0);
            check("out_pc", out_pc, exp_pc);
            check("out_raw_instr", out_raw_instr, exp_instr);
        end
    endtask

    // Advance the model across the rising edge using the inputs applied by drive().
    task automatic tick();
        bit done;
        bit pop;
        bit disc_now;
        @(posedge clk);
        if (d_rst) begin
            q.delete();
            m_pc = PC_RESET;
            m_busy = 0;
            m_disc = 0;
            m_addr = PC_RESET;
            m_init = 1;
            mem_wait = 0;
            new_lat();
        end else begin
            done = e_req && d_ok;
            pop = (q.size() != 0) && d_rdy;
            disc_now = m_busy && m_disc;
            if (d_rdr) begin
                q.delete();
                m_pc = {d_rpc[63:2], 2'b00};
                m_busy = e_req && !done;
                m_disc = 1;
                m_addr = e_addr;
            end else begin
                if (pop) void'(q.pop_front());
                if (done && !disc_now) begin
                    q.push_back('{instr: mem_data(e_addr), pc: e_addr});
                    m_pc = e_addr + 64'd4;
                end
                m_busy = e_req && !done;
                m_disc = disc_now && !done;
                m_addr = e_addr;
            end
            if (done || !e_req) begin
                mem_wait = 0;
                new_lat();
            end else begin
                mem_wait++;
            end
        end
    endtask

    vec_t vecs[15];

    initial begin
        int k;
        bit          r_rst, r_rdr, r_rdy;
        logic [63:0] r_pc;
        n_checks = 0; n_fail = 0; m_init = 0; m_busy = 0; m_disc = 0;
        m_pc = PC_RESET; m_addr = PC_RESET; mem_wait = 0; lat_mode = 0; mem_lat = 0;
        reset = 1; redirect_valid = 0; redirect_pc = '0; out_ready = 0;
        iresp_data_ok = 0; iresp_addr_ok = 0; iresp_data = '0;

        // Zero-latency memory: streaming with out_ready=1, then filling with out_ready=0.
        vecs[0]  = '{1, 0, 0, 64'h0,          0, 64'h0};
        vecs[1]  = '{0, 1, 1, 64'h8000_0000,  0, 64'h0};
        vecs[2]  = '{0, 1, 1, 64'h8000_0004,  1, 64'h8000_0000};
        vecs[3]  = '{0, 1, 1, 64'h8000_0008,  1, 64'h8000_0004};
        vecs[4]  = '{0, 1, 1, 64'h8000_000C,  1, 64'h8000_0008};
        vecs[5]  = '{1, 0, 0, 64'h0,          0, 64'h0};
        vecs[6]  = '{0, 0, 1, 64'h8000_0000,  0, 64'h0};
        vecs[7]  = '{0, 0, 1, 64'h8000_0004,  1, 64'h8000_0000};
        vecs[8]  = '{0, 0, 1, 64'h8000_0008,  1, 64'h8000_0000};
        vecs[9]  = '{0, 0, 1, 64'h8000_000C,  1, 64'h8000_0000};
        vecs[10] = '{0, 0, 0, 64'h0,          1, 64'h8000_0000};
        vecs[11] = '{0, 0, 0, 64'h0,          1, 64'h8000_0000};
        vecs[12] = '{0, 1, 0, 64'h0,          1, 64'h8000_0000};
        vecs[13] = '{0, 0, 1, 64'h8000_0010,  1, 64'h8000_0004};
        vecs[14] = '{0, 0, 0, 64'h0,          1, 64'h8000_0004};

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, 0, '0, vecs[i].rdy);
            check($sformatf("tbl%0d_req", i), ireq_valid, vecs[i].exp_req);
            if (vecs[i].exp_req) check($sformatf("tbl%0d_addr", i), ireq_addr, vecs[i].exp_addr);
            if (!vecs[i].rst) begin
                check($sformatf("tbl%0d_ov", i), out_valid, vecs[i].exp_ov);
                check($sformatf("tbl%0d_pc", i), out_pc, vecs[i].exp_pc);
            end
            tick();
        end

        // data_ok three cycles late: address held for four cycles, then +4.
        lat_mode = 3;
        drive(1, 0, '0, 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, '0, 0);
            check("hold_req", ireq_valid, 1);
            check("hold_addr", ireq_addr, PC_RESET);
            check("hold_ov", out_valid, 0);
            tick();
        end
        drive(0, 0, '0, 0);
        check("next_addr", ireq_addr, PC_RESET + 64'd4);
        check("lat_out_pc", out_pc, PC_RESET);
        tick();

        // Redirect while waiting: old request held and its data dropped.
        drive(0, 1, 64'h8000_1002, 0); tick();
        drive(0, 0, '0, 0);
        check("flush_ov", out_valid, 0);
        check("disc_addr", ireq_addr, PC_RESET + 64'd4);
        tick();
        drive(0, 0, '0, 0);
        check("disc_addr_ok", ireq_addr, PC_RESET + 64'd4);
        lat_mode = 0;
        tick();
        drive(0, 0, '0, 0);
        check("redir_addr", ireq_addr, 64'h8000_1000);
        check("drop_ov", out_valid, 0);
        tick();
        drive(0, 0, '0, 0);
        check("redir_out_pc", out_pc, 64'h8000_1000);
        tick();

        // Redirect coinciding with data_ok while the credit is exhausted.
        lat_mode = 1;
        drive(1, 0, '0, 0); tick();
        k = 0;
        while (!(m_busy && q.size() == DEPTH - 1) && k < 20) begin
            drive(0, 0, '0, 0); tick(); k++;
        end
        check("fill_budget", k < 20, 1);
        drive(0, 1, 64'h8000_2000, 1);
        check("full_ov", out_valid, 1);
        tick();
        drive(0, 0, '0, 1);
        check("rdo_ov", out_valid, 0);
        check("rdo_req", ireq_valid, 1);
        check("rdo_addr", ireq_addr, 64'h8000_2000);
        tick();

        // PC wrap to zero, then reset in the middle of a wait.
        lat_mode = 0;
        drive(1, 0, '0, 0); tick();
        drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0); tick();
        drive(0, 0, '0, 0);
        check("wrap_hi", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        lat_mode = 3;
        tick();
        drive(0, 0, '0, 0);
        check("wrap_zero", ireq_addr, 64'h0);
        tick();
        drive(0, 0, '0, 0);
        check("wait_addr", ireq_addr, 64'h0);
        tick();
        drive(1, 0, '0, 0);
        check("rst_req", ireq_valid, 0);
        tick();
        drive(1, 0, '0, 0);
        check("rst_req2", ireq_valid, 0);
        check("rst_ov", out_valid, 0);
        tick();
        drive(0, 0, '0, 0);
        check("post_rst_ov", out_valid, 0);
        check("post_rst_addr", ireq_addr, PC_RESET);
        tick();

        // Randomized traffic with random latency, redirects and back-pressure.
        lat_mode = -1;
        drive(1, 0, '0, 0); tick();
        for (int i = 0; i < 1500; i++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            r_rdr = ($urandom_range(0, 15) == 0);
            r_pc  = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15))
                                                : {$urandom, $urandom};
            r_rdy = ($urandom_range(0, 3) != 0);
            drive(r_rst, r_rdr, r_pc, r_rdy);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised fetch stage that owns the PC and drives the instruction bus with a full valid/addr_ok/data_ok handshake.
- Buffers returned instructions in a DEPTH-entry FIFO and hands them to decode over a valid/ready interface.
- Supports redirects from branches, jumps and exceptions. Any response still in flight when a redirect arrives is discarded.
- Sits between the core's PC/redirect logic and decode, where the combinational fetch passthrough used to be.

Parameters:
- DEPTH, 4, number of instruction-queue entries; power of two, ≥2.
- PC_RESET, 64'h8000_0000, first fetch address after reset.
- XLEN, 64, PC width.
- ILEN, 32, instruction width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ireq_valid  out  1  instruction-bus request valid.
- ireq_addr  out  XLEN  request address; always 4-byte aligned.
- iresp_addr_ok  in  1  bus accepted the address (informational only; does not change the hold rule below).
- iresp_data_ok  in  1  response data valid this cycle; completes the request.
- iresp_data  in  ILEN  returned instruction.
- redirect_valid  in  1  one-cycle redirect pulse.
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts the head.
- out_raw_instr  out  ILEN  head instruction.
- out_pc  out  XLEN  head PC.
- out_is_bubble  out  1  equals ~out_valid.

Behaviour:
- Reset (synchronous): pc_q=PC_RESET, FSM=IDLE, queue empty. Outputs: out_valid=0, out_is_bubble=1, out_raw_instr=0, out_pc=0. ireq_valid=0 during the reset cycle.
- Bus rule: once ireq_valid is asserted, ireq_valid and ireq_addr stay stable until the cycle in which iresp_data_ok=1. The request is then complete. Back-to-back requests are allowed in the following cycle.
- Credit: a request may be issued only if count + inflight < DEPTH. Entries reserved by an in-flight request are never overrun.
- FSM IDLE: drive ireq_valid=1, ireq_addr=pc_q when credit is available.
  - data_ok in the same cycle: push {iresp_data, pc_q}, pc_q += 4, stay IDLE.
  - Otherwise go to WAIT.
- FSM WAIT: hold the request.
  - On data_ok: push, pc_q += 4, go to IDLE.
- FSM DISCARD: hold the old request.
  - On data_ok: drop the data, go to IDLE. pc_q already holds the redirect target.
- Redirect (highest priority, any state):
  - Flush the queue (count=0, pointers reset).
  - pc_q = {redirect_pc[XLEN-1:2], 2'b00}.
  - No push occurs this cycle.
  - Pops with out_ready in the redirect cycle are ignored (the queue is empty afterwards).
  - IDLE with no request issued this cycle → stay IDLE; the new pc is issued next cycle.
  - IDLE with a request issued and no data_ok, or WAIT without data_ok → DISCARD.
  - Redirect together with data_ok (IDLE or WAIT) → data dropped, next state IDLE.
  - Redirect in DISCARD → update pc_q, stay DISCARD; also go to IDLE if data_ok.
  - A second redirect overrides the first.
- Queue:
  - Circular buffer; head/tail pointers of $clog2(DEPTH) bits wrap naturally; count is $clog2(DEPTH+1) bits.
  - Push and pop in the same cycle: count unchanged.
  - Pop when out_valid && out_ready.
  - Outputs are registered from the head entry: out_valid = (count != 0).
  - Push to empty queue: visible on out_* the next cycle (1-cycle data_ok → out_valid latency).
  - Full queue: no new request is issued. The head remains stable while out_ready=0.
- Arithmetic: PC increment is modulo 2^XLEN; wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0 is legal.

Test Plan:
- Reset release, memory with data_ok in the same cycle, out_ready=1:
  - ireq_addr sequence 8000_0000, 8000_0004, 8000_0008.
  - out_pc follows one cycle later; out_is_bubble=0 from the second cycle onward.
- out_ready=0, DEPTH=4, zero-latency memory:
  - Exactly 4 pushes, then ireq_valid=0.
  - out_pc stays 8000_0000.
  - Raise out_ready → one request re-issued per freed slot.
- data_ok delayed 3 cycles:
  - ireq_addr held stable for all 4 cycles.
  - Entry pushed on the data_ok cycle; next address is +4.
- Redirect to 8000_1002 while in WAIT (data_ok 2 cycles later):
  - Queue flushed; old address held until data_ok; its data dropped.
  - Next request is 8000_1000; out_pc of the first valid output is 8000_1000.
- Redirect in the same cycle as data_ok and out_ready=1 with a full queue:
  - Nothing pushed; queue empty next cycle.
  - Next ireq_addr = redirect target.
- pc_q = FFFF_FFFF_FFFF_FFFC via redirect:
  - Next fetch address is 0.
  - Synchronous reset asserted mid-WAIT → ireq_valid=0 and queue empty the next cycle.
